// File: rtl/pc_pkg.sv
// Shared types and default constants for the fetch-stage PC generator.
//   pc_state_e : fetch FSM state encoding
//   pc_t       : PC value at default width
package pc_pkg;

  localparam int unsigned XLEN_DEF       = 32;
  localparam int unsigned INC_DEF        = 4;
  localparam int unsigned ALIGN_LSBS_DEF = 2;

  typedef logic [XLEN_DEF-1:0] pc_t;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } pc_state_e;

endpackage : pc_pkg

// File: rtl/pc_gen.sv
// Program-counter generator for the fetch stage.
// Holds the fetch PC and selects the next PC from, highest priority first:
// trap entry, misaligned redirect (handled as a trap), trap return,
// aligned redirect, halt, sequential advance.
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   fetch_ready_i         fetch accepts pc_o this cycle
//   stall_i               hold PC
//   halt_i                request halt of fetch
//   redirect_i/_target_i  branch/jump taken and its target
//   trap_i, trap_pc_i,    trap entry, trapping PC, handler base
//   trap_vec_i
//   trap_ret_i            return from trap to epc_o
//   pc_o, pc_valid_o      current fetch PC and its valid flag
//   epc_o                 saved exception PC
//   misalign_o            one-cycle pulse on misaligned redirect
//   halted_o              fetch is halted
module pc_gen
  import pc_pkg::*;
#(
  parameter int unsigned      XLEN       = XLEN_DEF,
  parameter logic [XLEN-1:0]  RESET_VEC  = '0,
  parameter int unsigned      INC        = INC_DEF,
  parameter int unsigned      ALIGN_LSBS = ALIGN_LSBS_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            fetch_ready_i,
  input  logic            stall_i,
  input  logic            halt_i,
  input  logic            redirect_i,
  input  logic [XLEN-1:0] redirect_target_i,
  input  logic            trap_i,
  input  logic [XLEN-1:0] trap_pc_i,
  input  logic [XLEN-1:0] trap_vec_i,
  input  logic            trap_ret_i,
  output logic [XLEN-1:0] pc_o,
  output logic            pc_valid_o,
  output logic [XLEN-1:0] epc_o,
  output logic            misalign_o,
  output logic            halted_o
);

  // Low bits that must be clear in a redirect target; empty when ALIGN_LSBS=0.
  localparam logic [XLEN-1:0] ALIGN_MASK = ~({XLEN{1'b1}} << ALIGN_LSBS);
  localparam logic [XLEN-1:0] INC_W      = XLEN'(INC);

  pc_state_e       state_q, state_d;
  logic [XLEN-1:0] pc_d, epc_d;
  logic            misalign_d;
  logic            pc_valid_d;
  logic            halted_d;
  logic            misaligned;
  logic            advance;

  assign misaligned = redirect_i && (|(redirect_target_i & ALIGN_MASK));
  assign advance    = (state_q == RUN) && pc_valid_o && fetch_ready_i && !stall_i;

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= BOOT;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and next-PC selection.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_o;
    epc_d      = epc_o;
    misalign_d = 1'b0;

    unique case (state_q)
      // BOOT presents RESET_VEC unvalidated for one cycle; events are ignored.
      BOOT: state_d = RUN;

      RUN, HALT: begin
        if (trap_i) begin
          pc_d    = trap_vec_i;
          epc_d   = trap_pc_i;
          state_d = RUN;
        end else if (misaligned) begin
          pc_d       = trap_vec_i;
          epc_d      = redirect_target_i;
          misalign_d = 1'b1;
          state_d    = RUN;
        end else if (trap_ret_i) begin
          pc_d    = epc_o;
          state_d = RUN;
        end else if (redirect_i) begin
          pc_d    = redirect_target_i;
          state_d = RUN;
        end else if (halt_i && (state_q == RUN)) begin
          state_d = HALT;
        end else if (advance) begin
          // Wraps modulo 2^XLEN by construction.
          pc_d = pc_o + INC_W;
        end
      end

      default: state_d = BOOT;
    endcase

    pc_valid_d = (state_d == RUN);
    halted_d   = (state_d == HALT);
  end

  // Registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_o       <= RESET_VEC;
      epc_o      <= '0;
      pc_valid_o <= 1'b0;
      misalign_o <= 1'b0;
      halted_o   <= 1'b0;
    end else begin
      pc_o       <= pc_d;
      epc_o      <= epc_d;
      pc_valid_o <= pc_valid_d;
      misalign_o <= misalign_d;
      halted_o   <= halted_d;
    end
  end

endmodule : pc_gen

// File: tb/tb_pc_gen.sv
// Directed self-checking bench for pc_gen (RESET_VEC = 32'h1000).
module tb_pc_gen;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        fetch_ready_i;
  logic        stall_i;
  logic        halt_i;
  logic        redirect_i;
  logic [31:0] redirect_target_i;
  logic        trap_i;
  logic [31:0] trap_pc_i;
  logic [31:0] trap_vec_i;
  logic        trap_ret_i;
  logic [31:0] pc_o;
  logic        pc_valid_o;
  logic [31:0] epc_o;
  logic        misalign_o;
  logic        halted_o;

  int n_tests = 0;
  int n_fail  = 0;

  pc_gen #(
    .XLEN      (32),
    .RESET_VEC (32'h0000_1000),
    .INC       (4),
    .ALIGN_LSBS(2)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .fetch_ready_i    (fetch_ready_i),
    .stall_i          (stall_i),
    .halt_i           (halt_i),
    .redirect_i       (redirect_i),
    .redirect_target_i(redirect_target_i),
    .trap_i           (trap_i),
    .trap_pc_i        (trap_pc_i),
    .trap_vec_i       (trap_vec_i),
    .trap_ret_i       (trap_ret_i),
    .pc_o             (pc_o),
    .pc_valid_o       (pc_valid_o),
    .epc_o            (epc_o),
    .misalign_o       (misalign_o),
    .halted_o         (halted_o)
  );

  always #5 clk = ~clk;

  // One active edge, then settle before sampling or driving.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; fetch_ready_i = 1'b1;
    step(); step();
    n_tests++; if (pc_o !== 32'h1000) begin n_fail++; $display("FAIL reset_pc: got %h expected %h", pc_o, 32'h1000); end
    n_tests++; if (pc_valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", pc_valid_o); end
    n_tests++; if (epc_o !== 32'h0) begin n_fail++; $display("FAIL reset_epc: got %h expected 0", epc_o); end
    n_tests++; if (misalign_o !== 1'b0 || halted_o !== 1'b0) begin n_fail++; $display("FAIL reset_flags: got misalign=%b halted=%b expected 0 0", misalign_o, halted_o); end
    rst_n = 1'b1;
    step();
    n_tests++; if (pc_valid_o !== 1'b1 || pc_o !== 32'h1000) begin n_fail++; $display("FAIL boot_first_fetch: got valid=%b pc=%h expected 1 00001000", pc_valid_o, pc_o); end
    step();
    n_tests++; if (pc_o !== 32'h1004) begin n_fail++; $display("FAIL seq_1004: got %h expected %h", pc_o, 32'h1004); end
    step();
    n_tests++; if (pc_o !== 32'h1008) begin n_fail++; $display("FAIL seq_1008: got %h expected %h", pc_o, 32'h1008); end
  endtask

  task automatic test_stall();
    stall_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      n_tests++; if (pc_o !== 32'h1008) begin n_fail++; $display("FAIL stall_hold[%0d]: got %h expected %h", i, pc_o, 32'h1008); end
    end
    stall_i = 1'b0; fetch_ready_i = 1'b0;
    for (int i = 0; i < 2; i++) begin
      step();
      n_tests++; if (pc_o !== 32'h1008) begin n_fail++; $display("FAIL notready_hold[%0d]: got %h expected %h", i, pc_o, 32'h1008); end
    end
    fetch_ready_i = 1'b1;
    step();
    n_tests++; if (pc_o !== 32'h100C) begin n_fail++; $display("FAIL stall_release: got %h expected %h", pc_o, 32'h100C); end
  endtask

  task automatic test_redirect();
    stall_i = 1'b1; redirect_i = 1'b1; redirect_target_i = 32'h2000;
    step();
    n_tests++; if (pc_o !== 32'h2000) begin n_fail++; $display("FAIL redirect_over_stall: got %h expected %h", pc_o, 32'h2000); end
    n_tests++; if (misalign_o !== 1'b0) begin n_fail++; $display("FAIL redirect_aligned_flag: got %b expected 0", misalign_o); end
    stall_i = 1'b0; redirect_target_i = 32'h2002; trap_vec_i = 32'h0080;
    step();
    n_tests++; if (pc_o !== 32'h0080) begin n_fail++; $display("FAIL misalign_pc: got %h expected %h", pc_o, 32'h0080); end
    n_tests++; if (epc_o !== 32'h2002) begin n_fail++; $display("FAIL misalign_epc: got %h expected %h", epc_o, 32'h2002); end
    n_tests++; if (misalign_o !== 1'b1) begin n_fail++; $display("FAIL misalign_pulse: got %b expected 1", misalign_o); end
    redirect_i = 1'b0;
    step();
    n_tests++; if (misalign_o !== 1'b0) begin n_fail++; $display("FAIL misalign_pulse_end: got %b expected 0", misalign_o); end
    n_tests++; if (pc_o !== 32'h0084 || epc_o !== 32'h2002) begin n_fail++; $display("FAIL after_misalign: got pc=%h epc=%h expected 00000084 00002002", pc_o, epc_o); end
  endtask

  task automatic test_trap();
    trap_i = 1'b1; trap_pc_i = 32'h3010; trap_vec_i = 32'h0080;
    redirect_i = 1'b1; redirect_target_i = 32'h5000;
    step();
    n_tests++; if (pc_o !== 32'h0080) begin n_fail++; $display("FAIL trap_pc: got %h expected %h", pc_o, 32'h0080); end
    n_tests++; if (epc_o !== 32'h3010) begin n_fail++; $display("FAIL trap_epc: got %h expected %h", epc_o, 32'h3010); end
    trap_i = 1'b0; redirect_i = 1'b0; fetch_ready_i = 1'b0;
    step();
    n_tests++; if (pc_o !== 32'h0080) begin n_fail++; $display("FAIL trap_hold: got %h expected %h", pc_o, 32'h0080); end
    // trap return wins over a simultaneous aligned redirect
    trap_ret_i = 1'b1; redirect_i = 1'b1; redirect_target_i = 32'h7000;
    step();
    n_tests++; if (pc_o !== 32'h3010) begin n_fail++; $display("FAIL trap_ret_pc: got %h expected %h", pc_o, 32'h3010); end
    n_tests++; if (epc_o !== 32'h3010) begin n_fail++; $display("FAIL trap_ret_epc: got %h expected %h", epc_o, 32'h3010); end
    trap_ret_i = 1'b0; redirect_i = 1'b0; fetch_ready_i = 1'b1;
  endtask

  task automatic test_halt();
    halt_i = 1'b1;
    step();
    n_tests++; if (halted_o !== 1'b1 || pc_valid_o !== 1'b0) begin n_fail++; $display("FAIL halt_enter: got halted=%b valid=%b expected 1 0", halted_o, pc_valid_o); end
    n_tests++; if (pc_o !== 32'h3010) begin n_fail++; $display("FAIL halt_pc: got %h expected %h", pc_o, 32'h3010); end
    halt_i = 1'b0;
    step(); step();
    n_tests++; if (halted_o !== 1'b1 || pc_o !== 32'h3010) begin n_fail++; $display("FAIL halt_stay: got halted=%b pc=%h expected 1 00003010", halted_o, pc_o); end
    redirect_i = 1'b1; redirect_target_i = 32'h4000;
    step();
    n_tests++; if (halted_o !== 1'b0 || pc_valid_o !== 1'b1 || pc_o !== 32'h4000) begin n_fail++; $display("FAIL halt_exit: got halted=%b valid=%b pc=%h expected 0 1 00004000", halted_o, pc_valid_o, pc_o); end
    redirect_i = 1'b0;
  endtask

  task automatic test_wrap();
    redirect_i = 1'b1; redirect_target_i = 32'hFFFF_FFFC;
    step();
    n_tests++; if (pc_o !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL wrap_setup: got %h expected %h", pc_o, 32'hFFFF_FFFC); end
    redirect_i = 1'b0;
    step();
    n_tests++; if (pc_o !== 32'h0 || misalign_o !== 1'b0) begin n_fail++; $display("FAIL wrap: got pc=%h misalign=%b expected 00000000 0", pc_o, misalign_o); end
  endtask

  task automatic test_reset_mid();
    redirect_i = 1'b1; redirect_target_i = 32'h6000; rst_n = 1'b0;
    step();
    n_tests++; if (pc_o !== 32'h1000 || pc_valid_o !== 1'b0) begin n_fail++; $display("FAIL midreset_pc: got pc=%h valid=%b expected 00001000 0", pc_o, pc_valid_o); end
    n_tests++; if (epc_o !== 32'h0 || halted_o !== 1'b0) begin n_fail++; $display("FAIL midreset_state: got epc=%h halted=%b expected 0 0", epc_o, halted_o); end
    // trap during the BOOT cycle is ignored
    redirect_i = 1'b0; rst_n = 1'b1; trap_i = 1'b1; trap_pc_i = 32'h9000;
    step();
    n_tests++; if (pc_o !== 32'h1000 || epc_o !== 32'h0 || pc_valid_o !== 1'b1) begin n_fail++; $display("FAIL boot_trap_ignored: got pc=%h epc=%h valid=%b expected 00001000 0 1", pc_o, epc_o, pc_valid_o); end
    trap_i = 1'b0;
    step();
    n_tests++; if (pc_o !== 32'h1004) begin n_fail++; $display("FAIL post_reset_advance: got %h expected %h", pc_o, 32'h1004); end
  endtask

  initial begin
    rst_n = 1'b0; fetch_ready_i = 1'b0; stall_i = 1'b0; halt_i = 1'b0;
    redirect_i = 1'b0; redirect_target_i = '0; trap_i = 1'b0;
    trap_pc_i = '0; trap_vec_i = '0; trap_ret_i = 1'b0;
    #1;
    test_reset();
    test_stall();
    test_redirect();
    test_trap();
    test_halt();
    test_wrap();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_pc_gen
